// File: rtl/debounce_mc.sv
// Multi-channel key debouncer: 2-FF sync, prescaled sampling, per-channel
// agreement counters, edge pulses, sticky event flags and a Wishbone-style register port.
module debounce_mc #(
  parameter int               NCH        = 4,
  parameter int               DSIZE      = 8,
  parameter int               ASIZE      = 2,
  parameter logic             IDLE       = 1'b1,
  parameter logic [DSIZE-1:0] PRESC_RST  = 8'd1,
  parameter logic [DSIZE-1:0] THRESH_RST = 8'd99
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [ASIZE-1:0] i_wb_adr,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [DSIZE-1:0] i_wb_dat,
  output logic             o_wb_ack,
  output logic [DSIZE-1:0] o_wb_dat,
  input  logic [NCH-1:0]   i_key,
  output logic [NCH-1:0]   o_key,
  output logic [NCH-1:0]   o_rise,
  output logic [NCH-1:0]   o_fall,
  output logic             o_irq
);

  localparam logic [ASIZE-1:0] ADR_PRESC  = ASIZE'(0);
  localparam logic [ASIZE-1:0] ADR_THRESH = ASIZE'(1);
  localparam logic [ASIZE-1:0] ADR_LEVEL  = ASIZE'(2);
  localparam logic [ASIZE-1:0] ADR_EVENT  = ASIZE'(3);

  logic [NCH-1:0]   sync1, sync2;
  logic [DSIZE-1:0] presc, thresh, presc_cnt;
  logic [NCH-1:0]   event_r, flip, clr;
  logic [DSIZE-1:0] rd_data;
  logic             tick, wb_hit, wr_en;

  // Handshake: a strobe is accepted on the clock ack rises; ack drops the
  // following clock, so a held strobe is serviced every other clock.
  assign wb_hit = i_wb_stb & ~o_wb_ack;
  assign wr_en  = wb_hit & i_wb_we;
  assign tick   = (presc_cnt == '0);
  assign clr    = (wr_en && i_wb_adr == ADR_EVENT) ? i_wb_dat[NCH-1:0] : '0;
  assign o_irq  = |event_r;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= {NCH{IDLE}};
      sync2 <= {NCH{IDLE}};
    end else begin
      sync1 <= i_key;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc     <= PRESC_RST;
      thresh    <= THRESH_RST;
      presc_cnt <= '0;
    end else begin
      if (wr_en && i_wb_adr == ADR_PRESC) begin
        presc     <= i_wb_dat;
        presc_cnt <= i_wb_dat;
      end else if (tick) begin
        presc_cnt <= presc;
      end else begin
        presc_cnt <= presc_cnt - DSIZE'(1);
      end
      if (wr_en && i_wb_adr == ADR_THRESH) thresh <= i_wb_dat;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [DSIZE-1:0] cnt;
    logic             key_q, rise_q, fall_q;

    // >= lets a lowered threshold flip a channel that already counted past it.
    assign flip[ch]   = tick & (sync2[ch] != key_q) & (cnt >= thresh);
    assign o_key[ch]  = key_q;
    assign o_rise[ch] = rise_q;
    assign o_fall[ch] = fall_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt    <= '0;
        key_q  <= IDLE;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (tick) begin
          if (sync2[ch] == key_q) begin
            cnt <= '0;
          end else if (flip[ch]) begin
            cnt    <= '0;
            key_q  <= sync2[ch];
            rise_q <= sync2[ch];
            fall_q <= ~sync2[ch];
          end else begin
            cnt <= cnt + DSIZE'(1);
          end
        end
      end
    end
  end

  // Set has priority over a simultaneous write-one-to-clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) event_r <= '0;
    else       event_r <= (event_r & ~clr) | flip;
  end

  always_comb begin
    rd_data = '0;
    case (i_wb_adr)
      ADR_PRESC:  rd_data = presc;
      ADR_THRESH: rd_data = thresh;
      ADR_LEVEL:  rd_data[NCH-1:0] = o_key;
      ADR_EVENT:  rd_data[NCH-1:0] = event_r;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      o_wb_ack <= wb_hit;
      o_wb_dat <= wb_hit ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_debounce_mc.sv
// Directed bench for debounce_mc: bus reads and flip levels go through an
// expected queue and are compared when the DUT acks or flips.
module tb_debounce_mc;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [1:0] i_wb_adr = '0;
  logic       i_wb_stb = 1'b0;
  logic       i_wb_we = 1'b0;
  logic [7:0] i_wb_dat = '0;
  logic       o_wb_ack;
  logic [7:0] o_wb_dat;
  logic [3:0] i_key = 4'hF;
  logic [3:0] o_key, o_rise, o_fall;
  logic       o_irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  debounce_mc dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wb_adr(i_wb_adr), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat),
    .o_wb_ack(o_wb_ack), .o_wb_dat(o_wb_dat),
    .i_key(i_key), .o_key(o_key), .o_rise(o_rise), .o_fall(o_fall), .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
      if (o_wb_ack) begin got = 1'b1; break; end
    end
    check(tag, got, 1'b1);
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [7:0] dat);
    @(negedge i_clk);
    i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_adr = adr; i_wb_dat = dat;
    wait_ack("wr_ack");
    i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] adr, input logic [7:0] exp, input string tag);
    logic [7:0] e;
    exp_q.push_back(exp);
    @(negedge i_clk);
    i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = adr;
    wait_ack({tag, "_ack"});
    e = exp_q.pop_front();
    check(tag, o_wb_dat, e);
    i_wb_stb = 1'b0;
  endtask

  // Waits for o_key[ch] to change; lat counts clocks from the stimulus edge.
  task automatic wait_flip(input int ch, input logic lvl, input int max_cyc, input string tag,
                           output int lat, output logic rise, output logic fall);
    logic cur = o_key[ch];
    logic [7:0] e;
    exp_q.push_back({7'd0, lvl});
    lat = 0; rise = 1'b0; fall = 1'b0;
    while (lat < max_cyc) begin
      @(posedge i_clk); #1; lat++;
      if (o_key[ch] !== cur) begin rise = o_rise[ch]; fall = o_fall[ch]; break; end
    end
    e = exp_q.pop_front();
    check(tag, {7'd0, o_key[ch]}, e);
  endtask

  initial begin
    int lat, bad;
    logic r, f;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_key", o_key, 4'hF);
    check("rst_pulses", {o_rise, o_fall}, 8'h00);
    check("rst_irq_ack", {o_irq, o_wb_ack}, 2'b00);
    check("rst_dat", o_wb_dat, 8'h00);
    @(negedge i_clk); i_rst = 1'b0;
    wb_read(2'd0, 8'd1,  "rst_presc");
    wb_read(2'd1, 8'd99, "rst_thresh");
    wb_read(2'd2, 8'h0F, "rst_level");
    wb_read(2'd3, 8'h00, "rst_event");

    // 1: PRESC=0, THRESH=3, ch0 falls: 2 sync clocks + 4 ticks
    wb_write(2'd0, 8'd0);
    wb_write(2'd1, 8'd3);
    wb_read(2'd0, 8'd0, "presc_rb");
    wb_read(2'd1, 8'd3, "thresh_rb");
    @(posedge i_clk); #1; i_key[0] = 1'b0;
    wait_flip(0, 1'b0, 20, "t1_key", lat, r, f);
    check("t1_latency", lat, 2 + 3 + 1);
    check("t1_fall_rise", {f, r}, 2'b10);
    @(posedge i_clk); #1;
    check("t1_pulse_1clk", {o_rise, o_fall}, 8'h00);
    check("t1_irq", o_irq, 1'b1);
    wb_read(2'd3, 8'h01, "t1_event");

    // 2: 3-tick glitch on ch1 must be absorbed
    @(posedge i_clk); #1; i_key[1] = 1'b0;
    repeat (3) @(posedge i_clk);
    #1; i_key[1] = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge i_clk); #1;
      if (o_key[1] !== 1'b1 || o_rise !== 4'h0 || o_fall !== 4'h0) bad++;
    end
    check("t2_glitch_quiet", bad, 0);
    check("t2_key", o_key, 4'hE);
    wb_read(2'd3, 8'h01, "t2_event");

    // 3: PRESC=9, THRESH=1: two ticks after sync, 13..22 clocks after edge
    wb_write(2'd0, 8'd9);
    wb_write(2'd1, 8'd1);
    @(posedge i_clk); #1; i_key[2] = 1'b0;
    wait_flip(2, 1'b0, 40, "t3_key", lat, r, f);
    check("t3_not_early", lat >= 13, 1'b1);
    check("t3_not_late", lat <= 22, 1'b1);
    check("t3_fall", {f, r}, 2'b10);

    // 4: W1C of the event register
    wb_read(2'd3, 8'h05, "t4_event");
    wb_write(2'd3, 8'h01);
    wb_read(2'd3, 8'h04, "t4_event_clr0");
    check("t4_irq_held", o_irq, 1'b1);
    wb_write(2'd2, 8'h00);
    wb_read(2'd2, 8'h0A, "t4_level_ro");
    wb_write(2'd3, 8'h04);
    check("t4_irq_low", o_irq, 1'b0);
    wb_read(2'd3, 8'h00, "t4_event_clr2");

    // 5: W1C of bit 0 lands on the clock ch0 flips back high: set wins
    wb_write(2'd0, 8'd0);
    wb_write(2'd1, 8'd3);
    @(posedge i_clk); #1; i_key[0] = 1'b1;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_adr = 2'd3; i_wb_dat = 8'h01;
    @(posedge i_clk); #1;
    check("t5_ack", o_wb_ack, 1'b1);
    check("t5_rise", {o_key[0], o_rise[0]}, 2'b11);
    i_wb_stb = 1'b0; i_wb_we = 1'b0;
    wb_read(2'd3, 8'h01, "t5_event_set_wins");
    check("t5_irq", o_irq, 1'b1);

    // 6: async reset with ch0 mid-count and a bus cycle in flight
    @(posedge i_clk); #1; i_key[0] = 1'b0;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    i_wb_stb = 1'b1; i_wb_adr = 2'd2;
    #1; i_rst = 1'b1;
    #1;
    check("t6_key", o_key, 4'hF);
    check("t6_ack_irq", {o_wb_ack, o_irq}, 2'b00);
    i_wb_stb = 1'b0;
    i_key = 4'hF;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); i_rst = 1'b0;
    wb_read(2'd0, 8'd1,  "t6_presc");
    wb_read(2'd1, 8'd99, "t6_thresh");
    wb_read(2'd2, 8'h0F, "t6_level");
    wb_read(2'd3, 8'h00, "t6_event");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
